// File: rtl/svm_weight_trainer_pkg.sv
// svm_pkg: shared widths, packing positions, sign convention and FSM
// encoding for the SVM weight trainer and the recall path it feeds.
// No ports; it is imported by every file of the trainer.
package svm_pkg;

  localparam int FEAT_W  = 7;
  localparam int WGT_W   = 8;
  localparam int PROD_W  = 14;
  localparam int SCORE_W = 16;
  localparam int MCNT_W  = 16;

  // Bit positions inside the packed weight and feature words.
  localparam int W1_LSB = 8;
  localparam int W2_LSB = 0;
  localparam int X1_LSB = 7;
  localparam int X2_LSB = 0;

  localparam logic SIGN_NEG = 1'b1;
  localparam logic [FEAT_W-1:0] MAG_MAX = {FEAT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SUM  = 2'd2,
    ST_UPD  = 2'd3
  } state_t;

  // A zero magnitude never carries a negative sign.
  function automatic logic [WGT_W-1:0] wgt_norm(input logic [WGT_W-1:0] w);
    return (w[FEAT_W-1:0] == '0) ? '0 : w;
  endfunction

endpackage

// File: rtl/svm_weight_trainer_if.sv
// svm_weight_trainer_if: bundles the trainer's load, sample, done and
// status signals.
//   master : drives load_valid/load_weights and sample_valid/feature/label;
//            observes sample_ready, weights, done_*, mistake_count.
//   slave  : the trainer side (directions reversed).
interface svm_weight_trainer_if;
  import svm_pkg::*;

  logic                 load_valid;
  logic [2*WGT_W-1:0]   load_weights;
  logic                 sample_valid;
  logic                 sample_ready;
  logic [2*FEAT_W-1:0]  sample_feature;
  logic                 sample_label;
  logic [2*WGT_W-1:0]   weights;
  logic                 done_valid;
  logic                 done_pred;
  logic                 done_mistake;
  logic [SCORE_W-1:0]   done_score;
  logic [MCNT_W-1:0]    mistake_count;

  modport master (
    output load_valid, load_weights, sample_valid, sample_feature, sample_label,
    input  sample_ready, weights, done_valid, done_pred, done_mistake,
           done_score, mistake_count
  );

  modport slave (
    input  load_valid, load_weights, sample_valid, sample_feature, sample_label,
    output sample_ready, weights, done_valid, done_pred, done_mistake,
           done_score, mistake_count
  );

endinterface

// File: rtl/svm_weight_trainer_sm_add_sat.sv
// sm_add_sat: adds a sign-magnitude delta to one sign-magnitude weight.
//   w_in  : current weight, [7] sign (1 = negative), [6:0] magnitude
//   d_mag : delta magnitude
//   d_neg : delta sign (1 = negative)
//   w_out : result; same-sign sums saturate at 127, a zero result has sign 0
module sm_add_sat
  import svm_pkg::*;
(
  input  logic [WGT_W-1:0]  w_in,
  input  logic [FEAT_W-1:0] d_mag,
  input  logic              d_neg,
  output logic [WGT_W-1:0]  w_out
);

  logic              w_neg;
  logic [FEAT_W-1:0] w_mag;
  logic [FEAT_W:0]   sum;
  logic [FEAT_W-1:0] r_mag;
  logic              r_neg;

  assign w_neg = w_in[WGT_W-1];
  assign w_mag = w_in[FEAT_W-1:0];
  assign sum   = {1'b0, w_mag} + {1'b0, d_mag};

  always_comb begin
    r_mag = w_mag;
    r_neg = w_neg;
    if (w_neg == d_neg) begin
      r_mag = sum[FEAT_W] ? MAG_MAX : sum[FEAT_W-1:0];
    end else if (w_mag >= d_mag) begin
      r_mag = w_mag - d_mag;
    end else begin
      r_mag = d_mag - w_mag;
      r_neg = d_neg;
    end
  end

  assign w_out = (r_mag == '0) ? '0 : {r_neg, r_mag};

endmodule

// File: rtl/svm_weight_trainer.sv
// svm_weight_trainer: online perceptron-style trainer for the 2-D SVM
// classifier; its weights output is the recall path's support-vector word.
//   Bus2IP_Clk   : clock, rising edge
//   Bus2IP_Reset : synchronous active-high reset
//   bus (slave)  : load request, sample handshake, done pulse, weights,
//                  mistake count
//   LR_SHIFT     : right shift of feature magnitudes for the update (0..6)
//
// state | meaning
// IDLE  | waiting; accepts a load or a sample
// MUL   | products x_i*|w_i| registered with their weight signs
// SUM   | sign-magnitude score, prediction and mistake registered
// UPD   | weight update on mistake, done pulse registered
module svm_weight_trainer
  import svm_pkg::*;
#(
  parameter int unsigned LR_SHIFT = 0
) (
  input logic                 Bus2IP_Clk,
  input logic                 Bus2IP_Reset,
  svm_weight_trainer_if.slave bus
);

  state_t state, state_nxt;
  logic   accept, load_en, mul_en, sum_en, upd_en;

  logic [FEAT_W-1:0]    x1_q, x2_q;
  logic                 label_q;
  logic [PROD_W-1:0]    p1_q, p2_q;
  logic                 p1_neg_q, p2_neg_q;
  logic [SCORE_W-1:0]   score_q;
  logic                 pred_q, mistake_q;
  logic [2*WGT_W-1:0]   wgt_q;
  logic [MCNT_W-1:0]    mcount_q;
  logic                 done_valid_q, done_pred_q, done_mistake_q;
  logic [SCORE_W-1:0]   done_score_q;

  logic [WGT_W-1:0]     w1, w2, w1_upd, w2_upd;
  logic [PROD_W-1:0]    p1_c, p2_c;
  logic [SCORE_W-2:0]   mag_c;
  logic                 sign_c;
  logic [FEAT_W-1:0]    d1, d2;
  logic                 d_neg;

  // ---------------- FSM ----------------
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load_en   = 1'b0;
    mul_en    = 1'b0;
    sum_en    = 1'b0;
    upd_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        load_en = bus.load_valid;
        if (bus.sample_valid && bus.sample_ready) begin
          accept    = 1'b1;
          state_nxt = ST_MUL;
        end
      end
      ST_MUL: begin
        mul_en    = 1'b1;
        state_nxt = ST_SUM;
      end
      ST_SUM: begin
        sum_en    = 1'b1;
        state_nxt = ST_UPD;
      end
      ST_UPD: begin
        upd_en    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A pending load blocks the sample so the load always wins in IDLE.
  assign bus.sample_ready = (state == ST_IDLE) && !bus.load_valid && !Bus2IP_Reset;

  // ---------------- datapath ----------------
  assign w1   = wgt_q[W1_LSB +: WGT_W];
  assign w2   = wgt_q[W2_LSB +: WGT_W];
  assign p1_c = PROD_W'(x1_q) * PROD_W'(w1[FEAT_W-1:0]);
  assign p2_c = PROD_W'(x2_q) * PROD_W'(w2[FEAT_W-1:0]);

  // Sign-magnitude add, identical to the recall path: an exact tie of
  // opposite-signed products gives +0.
  always_comb begin
    mag_c  = '0;
    sign_c = ~SIGN_NEG;
    if (p1_neg_q == p2_neg_q) begin
      mag_c  = {1'b0, p1_q} + {1'b0, p2_q};
      sign_c = p1_neg_q;
    end else if (p1_q > p2_q) begin
      mag_c  = {1'b0, p1_q - p2_q};
      sign_c = p1_neg_q;
    end else if (p2_q > p1_q) begin
      mag_c  = {1'b0, p2_q - p1_q};
      sign_c = p2_neg_q;
    end
  end

  assign d1    = x1_q >> LR_SHIFT;
  assign d2    = x2_q >> LR_SHIFT;
  assign d_neg = label_q ? ~SIGN_NEG : SIGN_NEG;

  sm_add_sat u_add_w1 (.w_in(w1), .d_mag(d1), .d_neg(d_neg), .w_out(w1_upd));
  sm_add_sat u_add_w2 (.w_in(w2), .d_mag(d2), .d_neg(d_neg), .w_out(w2_upd));

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      x1_q           <= '0;
      x2_q           <= '0;
      label_q        <= 1'b0;
      p1_q           <= '0;
      p2_q           <= '0;
      p1_neg_q       <= 1'b0;
      p2_neg_q       <= 1'b0;
      score_q        <= '0;
      pred_q         <= 1'b0;
      mistake_q      <= 1'b0;
      wgt_q          <= '0;
      mcount_q       <= '0;
      done_valid_q   <= 1'b0;
      done_pred_q    <= 1'b0;
      done_mistake_q <= 1'b0;
      done_score_q   <= '0;
    end else begin
      done_valid_q <= 1'b0;
      if (load_en) begin
        wgt_q    <= {wgt_norm(bus.load_weights[W1_LSB +: WGT_W]),
                     wgt_norm(bus.load_weights[W2_LSB +: WGT_W])};
        mcount_q <= '0;
      end
      if (accept) begin
        x1_q    <= bus.sample_feature[X1_LSB +: FEAT_W];
        x2_q    <= bus.sample_feature[X2_LSB +: FEAT_W];
        label_q <= bus.sample_label;
      end
      if (mul_en) begin
        p1_q     <= p1_c;
        p2_q     <= p2_c;
        p1_neg_q <= w1[WGT_W-1];
        p2_neg_q <= w2[WGT_W-1];
      end
      if (sum_en) begin
        score_q   <= {sign_c, mag_c};
        pred_q    <= (sign_c != SIGN_NEG);
        mistake_q <= ((sign_c != SIGN_NEG) != label_q);
      end
      if (upd_en) begin
        done_valid_q   <= 1'b1;
        done_pred_q    <= pred_q;
        done_mistake_q <= mistake_q;
        done_score_q   <= score_q;
        if (mistake_q) begin
          wgt_q <= {w1_upd, w2_upd};
          if (mcount_q != {MCNT_W{1'b1}}) mcount_q <= mcount_q + 1'b1;
        end
      end
    end
  end

  assign bus.weights       = wgt_q;
  assign bus.mistake_count = mcount_q;
  assign bus.done_valid    = done_valid_q;
  assign bus.done_pred     = done_pred_q;
  assign bus.done_mistake  = done_mistake_q;
  assign bus.done_score    = done_score_q;

endmodule

// File: tb/tb_svm_weight_trainer.sv
// Bench for svm_weight_trainer: two instances (LR_SHIFT 0 and 2) share one
// stimulus stream; a signed-integer reference model predicts each sample
// into per-instance queues that a negedge monitor pops on done_valid.
module tb_svm_weight_trainer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_weights = '0;
  logic        sample_valid = 1'b0;
  logic [13:0] sample_feature = '0;
  logic        sample_label = 1'b0;

  always #5 clk = ~clk;

  svm_weight_trainer_if if0 ();
  svm_weight_trainer_if if1 ();

  assign if0.load_valid     = load_valid;
  assign if0.load_weights   = load_weights;
  assign if0.sample_valid   = sample_valid;
  assign if0.sample_feature = sample_feature;
  assign if0.sample_label   = sample_label;
  assign if1.load_valid     = load_valid;
  assign if1.load_weights   = load_weights;
  assign if1.sample_valid   = sample_valid;
  assign if1.sample_feature = sample_feature;
  assign if1.sample_label   = sample_label;

  svm_weight_trainer #(.LR_SHIFT(0)) dut0 (.Bus2IP_Clk(clk), .Bus2IP_Reset(rst), .bus(if0));
  svm_weight_trainer #(.LR_SHIFT(2)) dut1 (.Bus2IP_Clk(clk), .Bus2IP_Reset(rst), .bus(if1));

  typedef struct {
    logic        pred;
    logic        mistake;
    logic [15:0] score;
    logic [15:0] wgt;
    logic [15:0] mcnt;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mw1[2];
  int   mw2[2];
  int   mcnt[2];
  int   shift_of[2] = '{0, 2};
  logic [15:0] last_score[2];
  logic        last_pred[2];
  logic        last_mis[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int dec(input logic [7:0] w);
    if (w[6:0] == 7'd0) return 0;
    return w[7] ? -int'(w[6:0]) : int'(w[6:0]);
  endfunction

  function automatic logic [7:0] enc(input int v);
    logic [7:0] r;
    r[7]   = (v < 0);
    r[6:0] = (v < 0) ? 7'(-v) : 7'(v);
    return r;
  endfunction

  function automatic int clamp(input int v);
    if (v > 127) return 127;
    if (v < -127) return -127;
    return v;
  endfunction

  // Reference: score is the true signed dot product, except that two
  // negative weights give a negative sign even when the sum is zero, and
  // mixed signs with a zero sum give +0.
  task automatic model_accept(input int x1, input int x2, input logic lab, input int hcyc);
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      int   s;
      int   mag;
      logic sg;
      s = x1 * mw1[d] + x2 * mw2[d];
      if (mw1[d] < 0 && mw2[d] < 0) sg = 1'b1;
      else if (mw1[d] >= 0 && mw2[d] >= 0) sg = 1'b0;
      else sg = (s < 0);
      mag = (s < 0) ? -s : s;
      e.pred    = !sg;
      e.mistake = (e.pred != lab);
      e.score   = {sg, 15'(mag)};
      if (e.mistake) begin
        mw1[d] = clamp(mw1[d] + (lab ? (x1 >> shift_of[d]) : -(x1 >> shift_of[d])));
        mw2[d] = clamp(mw2[d] + (lab ? (x2 >> shift_of[d]) : -(x2 >> shift_of[d])));
        if (mcnt[d] < 65535) mcnt[d]++;
      end
      e.wgt  = {enc(mw1[d]), enc(mw2[d])};
      e.mcnt = 16'(mcnt[d]);
      e.cyc  = hcyc + 4;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mw1[d] = 0; mw2[d] = 0; mcnt[d] = 0;
    end
  endtask

  task automatic mon_one(input int d, input logic dv, input logic pred, input logic mis,
                         input logic [15:0] sc, input logic [15:0] w, input logic [15:0] mc);
    exp_t e;
    if (!dv) return;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL dut%0d unexpected_done: got done_valid=1 expected no pulse", d);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("dut%0d done_cycle", d), cyc, e.cyc);
    chk($sformatf("dut%0d done_pred", d), pred, e.pred);
    chk($sformatf("dut%0d done_mistake", d), mis, e.mistake);
    chk($sformatf("dut%0d done_score", d), sc, e.score);
    chk($sformatf("dut%0d weights", d), w, e.wgt);
    chk($sformatf("dut%0d mistake_count", d), mc, e.mcnt);
    last_score[d] = sc;
    last_pred[d]  = pred;
    last_mis[d]   = mis;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_one(0, if0.done_valid, if0.done_pred, if0.done_mistake, if0.done_score,
              if0.weights, if0.mistake_count);
      mon_one(1, if1.done_valid, if1.done_pred, if1.done_mistake, if1.done_score,
              if1.weights, if1.mistake_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x1, input int x2, input logic lab);
    int n;
    n = 0;
    sample_valid   = 1'b1;
    sample_feature = {7'(x1), 7'(x2)};
    sample_label   = lab;
    while (1) begin
      @(negedge clk);
      if (if0.sample_ready) break;
      n++;
      if (n >= 20) break;
    end
    if (!if0.sample_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got sample_ready=0 for 20 cycles expected 1");
    end else begin
      chk("dut1 ready_at_accept", if1.sample_ready, 1);
      model_accept(x1, x2, lab, cyc);
    end
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d/%0d pending expected 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    tick();
  endtask

  task automatic do_load(input logic [15:0] w, input logic with_sample);
    load_valid   = 1'b1;
    load_weights = w;
    if (with_sample) begin
      sample_valid   = 1'b1;
      sample_feature = 14'($urandom);
      sample_label   = 1'($urandom);
    end
    @(negedge clk);
    chk("dut0 ready_during_load", if0.sample_ready, 0);
    chk("dut1 ready_during_load", if1.sample_ready, 0);
    for (int d = 0; d < 2; d++) begin
      mw1[d] = dec(w[15:8]); mw2[d] = dec(w[7:0]); mcnt[d] = 0;
    end
    tick();
    load_valid   = 1'b0;
    sample_valid = 1'b0;
    @(negedge clk);
    chk("dut0 load_weights", if0.weights, {enc(mw1[0]), enc(mw2[0])});
    chk("dut1 load_weights", if1.weights, {enc(mw1[1]), enc(mw2[1])});
    chk("dut0 load_mcount", if0.mistake_count, 0);
    tick();
  endtask

  initial begin
    int prev;
    int got;
    int n;
    int x1;
    int x2;
    logic lab;
    logic [15:0] w;

    model_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("reset ready0", if0.sample_ready, 0);
    chk("reset ready1", if1.sample_ready, 0);
    chk("reset weights", if0.weights, 16'h0000);
    chk("reset mcount", if0.mistake_count, 0);
    chk("reset done_valid", if0.done_valid, 0);
    chk("reset done_score", if0.done_score, 0);
    chk("reset done_pred", if0.done_pred, 0);
    chk("reset done_mistake", if0.done_mistake, 0);
    tick();
    rst = 1'b0;
    tick();

    // zero weights: +0 score, correct for a positive label
    send(5, 3, 1'b1);
    wait_idle();
    chk("t1 score", last_score[0], 16'h0000);
    chk("t1 pred", last_pred[0], 1);
    chk("t1 mistake", last_mis[0], 0);
    chk("t1 weights", if0.weights, 16'h0000);

    do_load(16'h8A05, 1'b0);
    send(4, 3, 1'b1);
    wait_idle();
    chk("t2 score", last_score[0], 16'h8019);
    chk("t2 weights", if0.weights, 16'h8608);
    chk("t2 mcount", if0.mistake_count, 1);

    do_load(16'h78E4, 1'b0);
    send(20, 30, 1'b1);
    wait_idle();
    chk("t3 score", last_score[0], 16'h8258);
    chk("t3 weights", if0.weights, 16'h7FC6);

    do_load(16'h0500, 1'b0);
    send(5, 0, 1'b0);
    wait_idle();
    chk("t4 score", last_score[0], 16'h0019);
    chk("t4 weights", if0.weights, 16'h0000);
    do_load(16'h8000, 1'b0);
    chk("t4 load_8000", if0.weights, 16'h0000);

    do_load(16'h8505, 1'b0);
    send(3, 3, 1'b1);
    wait_idle();
    chk("t5 tie_score", last_score[0], 16'h0000);
    chk("t5 tie_pred", last_pred[0], 1);
    chk("t5 tie_mistake", last_mis[0], 0);
    do_load(16'h0000, 1'b0);
    send(12, 8, 1'b0);
    wait_idle();
    chk("t5 lr2_score", last_score[1], 16'h0000);
    chk("t5 lr2_mistake", last_mis[1], 1);
    chk("t5 lr2_weights", if1.weights, 16'h8382);

    // held sample_valid with features changing every cycle
    do_load(16'h9A2C, 1'b0);
    prev = -1;
    got = 0;
    n = 0;
    x1 = int'($urandom_range(0, 127));
    x2 = int'($urandom_range(0, 127));
    lab = 1'($urandom);
    sample_valid = 1'b1;
    sample_feature = {7'(x1), 7'(x2)};
    sample_label = lab;
    while (got < 6 && n < 60) begin
      @(negedge clk);
      n++;
      if (if0.sample_ready) begin
        model_accept(x1, x2, lab, cyc);
        if (prev >= 0) chk("hold spacing", cyc - prev, 4);
        prev = cyc;
        got++;
      end
      tick();
      x1 = int'($urandom_range(0, 127));
      x2 = int'($urandom_range(0, 127));
      lab = 1'($urandom);
      sample_feature = {7'(x1), 7'(x2)};
      sample_label = lab;
    end
    sample_valid = 1'b0;
    chk("hold acceptances", got, 6);
    wait_idle();

    // load and sample together in IDLE: only the load happens
    do_load(16'h1B93, 1'b1);
    repeat (6) begin
      @(negedge clk);
      chk("load_wins no_done", if0.done_valid, 0);
    end
    tick();

    // reset sampled at T+2 aborts the sample
    do_load(16'h8A05, 1'b0);
    sample_valid = 1'b1;
    sample_feature = {7'd4, 7'd3};
    sample_label = 1'b1;
    @(negedge clk);
    chk("abort ready", if0.sample_ready, 1);
    tick();
    sample_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    repeat (6) begin
      @(negedge clk);
      chk("abort no_done0", if0.done_valid, 0);
      chk("abort no_done1", if1.done_valid, 0);
    end
    chk("abort weights", if0.weights, 16'h0000);
    chk("abort mcount", if0.mistake_count, 0);
    tick();

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        wait_idle();
        w = 16'($urandom);
        if ($urandom_range(0, 3) == 0) w[14:8] = 7'd0;
        if ($urandom_range(0, 3) == 0) w[6:0] = 7'd0;
        do_load(w, 1'($urandom));
      end
      x1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 127));
      x2 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 127));
      send(x1, x2, 1'($urandom));
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
